icache_dm: RTL and testbench

//   Direct-mapped, read-only instruction cache between the pipelined CPU fetch port (pc/instr)
//   and a multi-cycle instruction memory. Hits return the instruction combinationally in the

---
 rtl/icache_dm_if.sv | 9 +
 rtl/icache_dm.sv | 131 +++++++++++++
 tb/tb_icache_dm.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// icache_dm_if: word-read request/acknowledge bus between the cache and instruction memory
interface icache_dm_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with 4-word line refill over req/ack
module icache_dm #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_instr,
    output logic        cpu_stall,
    input  logic        inv,
    icache_dm_if.master mem,
    output logic [15:0] miss_count
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;
    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q [LINES];
    logic [TAG_BITS-1:0]   tag_d [LINES];
    logic [31:0]           data_q [LINES][4];
    logic [31:0]           data_d [LINES][4];
    logic [TAG_BITS-1:0]   rtag_q, rtag_d;
    logic [INDEX_BITS-1:0] ridx_q, ridx_d;
    logic [1:0]            word_q, word_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic                  discard_q, discard_d;
    logic [15:0]           miss_count_q, miss_count_d;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] pc_idx;
    logic [1:0]            pc_off;
    logic [1:0]            word_inc;
    logic                  hit;
    logic                  unused_pc;
    assign pc_tag     = cpu_pc[31:INDEX_BITS+4];
    assign pc_idx     = cpu_pc[INDEX_BITS+3:4];
    assign pc_off     = cpu_pc[3:2];
    assign unused_pc  = ^cpu_pc[1:0];
    assign word_inc   = word_q + 2'd1;
    assign hit        = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign cpu_instr  = hit ? data_q[pc_idx][pc_off] : 32'h0;
    assign cpu_stall  = ~hit;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign miss_count   = miss_count_q;
    // Next-state: miss detection, refill word sequencing, line validation and invalidation
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        rtag_d       = rtag_q;
        ridx_d       = ridx_q;
        word_d       = word_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        discard_d    = discard_q;
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                if (inv) begin
                    valid_d = '0;
                end else if (!hit) begin
                    state_d      = REFILL;
                    rtag_d       = pc_tag;
                    ridx_d       = pc_idx;
                    word_d       = 2'd0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = {pc_tag, pc_idx, 4'b0000};
                    miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
                end
            end
            REFILL: begin
                if (inv) begin
                    valid_d   = '0;
                    discard_d = 1'b1;
                end
                if (mem.mem_ack) begin
                    data_d[ridx_q][word_q] = mem.mem_rdata;
                    word_d     = word_inc;
                    mem_addr_d = {rtag_q, ridx_q, word_inc, 2'b00};
                    if (word_q == 2'd3) begin
                        mem_req_d = 1'b0;
                        state_d   = FILL_DONE;
                    end
                end
            end
            FILL_DONE: begin
                if (inv) begin
                    valid_d = '0;
                end else if (!discard_q) begin
                    valid_d[ridx_q] = 1'b1;
                    tag_d[ridx_q]   = rtag_q;
                end
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Control state with asynchronous active-low reset; reset aborts any refill in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            rtag_q       <= '0;
            ridx_q       <= '0;
            word_q       <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            discard_q    <= 1'b0;
            miss_count_q <= 16'h0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rtag_q       <= rtag_d;
            ridx_q       <= ridx_d;
            word_q       <= word_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            discard_q    <= discard_d;
            miss_count_q <= miss_count_d;
        end
    end
    // Tag and data storage needs no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized self-checking bench for icache_dm against a line-level cache model
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_pc = 32'h0;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        inv = 1'b0;
    logic [15:0] miss_count;
    icache_dm_if bus ();
    icache_dm #(.INDEX_BITS(4)) dut (
        .clk(clk), .reset(reset), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .cpu_stall(cpu_stall), .inv(inv), .mem(bus), .miss_count(miss_count)
    );
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    int mem_gap = 1;
    int mem_cnt = 0;
    int glitches = 0;
    bit mem_waiting = 0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] acks [$];
    bit m_valid [16];
    logic [23:0] m_tag [16];
    logic [15:0] m_miss = 16'h0;
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
    end
    // Memory: acknowledges every mem_gap-th requesting cycle; data word is address ^ A5A5_0000
    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_ack = 1'b0;
            mem_cnt = 0;
        end else begin
            if (mem_waiting && bus.mem_addr !== prev_addr) glitches++;
            if (mem_cnt >= mem_gap - 1) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;
                acks.push_back(bus.mem_addr);
                mem_cnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                mem_cnt++;
            end
        end
        mem_waiting = bus.mem_req && !bus.mem_ack;
        prev_addr = bus.mem_addr;
    end
    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {pc[31:2], 2'b00} ^ 32'hA5A5_0000;
    endfunction
    task automatic model_fill(input logic [31:0] pc);
        m_valid[pc[7:4]] = 1'b1;
        m_tag[pc[7:4]] = pc[31:8];
        if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    endtask
    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask
    task automatic fetch(input logic [31:0] pc);
        int n;
        int exp_n;
        bit hit;
        bit bad;
        logic [31:0] base;
        hit = m_valid[pc[7:4]] && (m_tag[pc[7:4]] == pc[31:8]);
        base = {pc[31:4], 4'h0};
        exp_n = hit ? 0 : 4 * mem_gap + 2;
        acks.delete();
        glitches = 0;
        n = 0;
        bad = 0;
        cpu_pc = pc;
        @(negedge clk); #1;
        while (cpu_stall && n < 200) begin
            if (cpu_instr !== 32'h0) bad = 1;
            n++;
            @(negedge clk); #1;
        end
        if (!hit) model_fill(pc);
        vectors++;
        if (n != exp_n) begin miscompares++; $display("FAIL stall_cycles pc=%h got %0d exp %0d", pc, n, exp_n); end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL instr_while_stalled pc=%h got nonzero exp 0", pc); end
        vectors++;
        if (cpu_instr !== exp_word(pc)) begin miscompares++; $display("FAIL instr pc=%h got %h exp %h", pc, cpu_instr, exp_word(pc)); end
        vectors++;
        if (miss_count !== m_miss) begin miscompares++; $display("FAIL miss_count pc=%h got %0d exp %0d", pc, miss_count, m_miss); end
        vectors++;
        if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL mem_req_idle pc=%h got %b exp 0", pc, bus.mem_req); end
        vectors++;
        if (acks.size() != (hit ? 0 : 4)) begin miscompares++; $display("FAIL ack_count pc=%h got %0d exp %0d", pc, acks.size(), hit ? 0 : 4); end
        if (!hit && acks.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (acks[i] !== base + 32'(4 * i)) begin miscompares++; $display("FAIL refill_addr pc=%h word %0d got %h exp %h", pc, i, acks[i], base + 32'(4 * i)); end
            end
        end
        vectors++;
        if (glitches != 0) begin miscompares++; $display("FAIL addr_stable pc=%h got %0d changes exp 0", pc, glitches); end
        @(posedge clk); #1;
    endtask
    task automatic inv_pulse();
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        model_clear();
        vectors++;
        if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL inv_idle_no_refill got mem_req=%b exp 0", bus.mem_req); end
    endtask
    task automatic refill_with_inv(input logic [31:0] pc, input logic [31:0] trig);
        int n;
        bit pulsed;
        logic [31:0] base;
        base = {pc[31:4], 4'h0};
        mem_gap = 1;
        acks.delete();
        n = 0;
        pulsed = 0;
        cpu_pc = pc;
        forever begin
            @(negedge clk); #1;
            if (!cpu_stall || n >= 200) break;
            n++;
            if (!pulsed && bus.mem_req && bus.mem_addr == trig) begin
                inv = 1'b1;
                pulsed = 1;
            end
            @(posedge clk); #1;
            inv = 1'b0;
        end
        model_clear();
        model_fill(pc);
        model_fill(pc);
        vectors++;
        if (n != 12) begin miscompares++; $display("FAIL inv_refill_stall pc=%h got %0d exp 12", pc, n); end
        vectors++;
        if (acks.size() != 8) begin miscompares++; $display("FAIL inv_refill_acks pc=%h got %0d exp 8", pc, acks.size()); end
        if (acks.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (acks[i] !== base + 32'(4 * (i % 4))) begin miscompares++; $display("FAIL inv_refill_addr %0d got %h exp %h", i, acks[i], base + 32'(4 * (i % 4))); end
            end
        end
        vectors++;
        if (cpu_instr !== exp_word(pc)) begin miscompares++; $display("FAIL inv_refill_instr got %h exp %h", cpu_instr, exp_word(pc)); end
        vectors++;
        if (miss_count !== m_miss) begin miscompares++; $display("FAIL inv_refill_miss_count got %0d exp %0d", miss_count, m_miss); end
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        cpu_pc = 32'h0000_0040;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall got %b exp 1", cpu_stall); end
        vectors++;
        if (cpu_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", cpu_instr); end
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_bus got req=%b addr=%h exp 0/0", bus.mem_req, bus.mem_addr); end
        vectors++;
        if (miss_count !== 16'h0) begin miscompares++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        m_miss = 16'h0;
    endtask
    task automatic test_cold_and_hits();
        mem_gap = 1;
        fetch(32'h0000_0040);
        fetch(32'h0000_0044);
        fetch(32'h0000_0048);
        fetch(32'h0000_004C);
    endtask
    task automatic test_conflict();
        fetch(32'h0000_0140);
        fetch(32'h0000_0040);
        vectors++;
        if (miss_count !== 16'd3) begin miscompares++; $display("FAIL conflict_miss_count got %0d exp 3", miss_count); end
    endtask
    task automatic test_gaps();
        mem_gap = 3;
        fetch(32'h0000_0088);
        fetch(32'h0000_0040);
        mem_gap = 1;
    endtask
    task automatic test_inv();
        inv_pulse();
        refill_with_inv(32'h0000_0040, 32'h0000_0044);
        refill_with_inv(32'h0000_0090, 32'h0000_009C);
        fetch(32'h0000_0044);
        inv_pulse();
        fetch(32'h0000_0044);
    endtask
    task automatic test_random();
        logic [31:0] pc;
        for (int k = 0; k < 40; k++) begin
            mem_gap = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) inv_pulse();
            pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
            fetch(pc);
        end
        mem_gap = 1;
    endtask
    task automatic test_reset_mid();
        int n;
        inv_pulse();
        cpu_pc = 32'h0000_0040;
        n = 0;
        forever begin
            @(negedge clk); #1;
            if ((bus.mem_req && bus.mem_addr == 32'h0000_0048) || n >= 50) break;
            n++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mid_bus got req=%b addr=%h exp 0/0", bus.mem_req, bus.mem_addr); end
        vectors++;
        if (miss_count !== 16'h0) begin miscompares++; $display("FAIL reset_mid_miss_count got %0d exp 0", miss_count); end
        vectors++;
        if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL reset_mid_stall got %b exp 1", cpu_stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        m_miss = 16'h0;
        fetch(32'h0000_0040);
    endtask
    task automatic test_saturation();
        force dut.miss_count_q = 16'hFFFD;
        #1;
        release dut.miss_count_q;
        m_miss = 16'hFFFD;
        fetch(32'h0000_1000);
        fetch(32'h0000_2000);
        fetch(32'h0000_3000);
        fetch(32'h0000_4004);
        vectors++;
        if (miss_count !== 16'hFFFF) begin miscompares++; $display("FAIL saturation got %h exp FFFF", miss_count); end
    endtask
    initial begin
        test_reset();
        test_cold_and_hits();
        test_conflict();
        test_gaps();
        test_inv();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
